// File: rtl/n64_vinfo_demuxctrl.sv
// N64 video-info and demux control: decodes the sync nibble on D_i, tracks lines per field,
// classifies PAL/480i and produces the per-pixel demux parameters for the colour demux stage.
module n64_vinfo_demuxctrl #(
  parameter int unsigned color_width_i = 7,
  parameter int unsigned pal_lines_th  = 300
) (
  input  logic                     nCLK,
  input  logic                     RST,
  input  logic                     nDSYNC,
  input  logic [color_width_i-1:0] D_i,
  input  logic [1:0]               deblur_cfg_i,
  input  logic                     n15bit_mode_i,
  output logic [4:0]               demuxparams_o,
  output logic [1:0]               vinfo_o
);

  localparam logic [9:0] PalTh    = 10'(pal_lines_th);
  localparam logic [9:0] LinesMax = 10'h3FF;

  logic [3:0] r_sync;
  logic [1:0] r_data_cnt;
  logic [9:0] r_line_cnt;
  logic [9:0] r_prev_lines;
  logic       r_frame_valid;
  logic       r_pal;
  logic       r_n64_480i;
  logic       r_ndo_deblur;
  logic       r_nblank_rgb;
  logic       r_n15bit_mode;

  logic       w_sync_phase;
  logic       w_hsync_ev;
  logic       w_vsync_ev;
  logic       w_n64_480i_nxt;
  logic       w_ndo_deblur_nxt;
  logic       w_nblank_rgb_nxt;
  logic       w_unused_d;

  // Only the sync nibble is decoded here; colour bits belong to the demux stage.
  assign w_unused_d = ^D_i[color_width_i-1:4];

  assign w_sync_phase = ~nDSYNC;
  assign w_hsync_ev   = w_sync_phase & r_sync[1] & ~D_i[1];
  assign w_vsync_ev   = w_sync_phase & r_sync[3] & ~D_i[3];

  // Interlace shows up as alternating line-count parity between consecutive fields.
  assign w_n64_480i_nxt = r_frame_valid ? (r_line_cnt[0] != r_prev_lines[0]) : r_n64_480i;

  always_comb begin
    w_ndo_deblur_nxt = 1'b1;
    if (deblur_cfg_i == 2'b00) begin
      w_ndo_deblur_nxt = w_n64_480i_nxt;
    end else if (deblur_cfg_i == 2'b01) begin
      w_ndo_deblur_nxt = 1'b0;
    end
  end

  always_comb begin
    w_nblank_rgb_nxt = r_nblank_rgb;
    if (r_ndo_deblur) begin
      w_nblank_rgb_nxt = 1'b1;
    end else if (w_sync_phase) begin
      w_nblank_rgb_nxt = w_hsync_ev ? 1'b1 : ~r_nblank_rgb;
    end
  end

  // sync_r resets to all-ones so only genuine falling edges after reset raise events.
  always_ff @(negedge nCLK) begin
    if (RST) begin
      r_sync     <= 4'hF;
      r_data_cnt <= 2'b00;
    end else if (w_sync_phase) begin
      r_sync     <= D_i[3:0];
      r_data_cnt <= 2'b01;
    end else begin
      r_data_cnt <= r_data_cnt + 2'd1;
    end
  end

  always_ff @(negedge nCLK) begin
    if (RST) begin
      r_line_cnt    <= '0;
      r_prev_lines  <= '0;
      r_frame_valid <= 1'b0;
      r_pal         <= 1'b0;
      r_n64_480i    <= 1'b0;
      r_ndo_deblur  <= 1'b1;
    end else if (w_vsync_ev) begin
      r_line_cnt    <= '0;
      r_prev_lines  <= r_line_cnt;
      r_frame_valid <= 1'b1;
      r_pal         <= (r_line_cnt > PalTh);
      r_n64_480i    <= w_n64_480i_nxt;
      r_ndo_deblur  <= w_ndo_deblur_nxt;
    end else if (w_hsync_ev && (r_line_cnt != LinesMax)) begin
      r_line_cnt    <= r_line_cnt + 10'd1;
    end
  end

  always_ff @(negedge nCLK) begin
    if (RST) begin
      r_nblank_rgb  <= 1'b1;
      r_n15bit_mode <= 1'b1;
    end else begin
      r_nblank_rgb  <= w_nblank_rgb_nxt;
      r_n15bit_mode <= n15bit_mode_i;
    end
  end

  assign demuxparams_o = {r_data_cnt, r_ndo_deblur, r_nblank_rgb, r_n15bit_mode};
  assign vinfo_o       = {r_pal, r_n64_480i};

endmodule
